// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode values,
// common to the transmit engine and a future receive engine.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // Parity bit from the XOR-reduction of the data word and the selected mode.
  function automatic logic parity_bit(input logic data_xor, input bit mode);
    return data_xor ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// FIFO read handshake plus serial-side status of the UART transmit engine.
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd_en,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restartable, flags the last
// and second-to-last cycle of every bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (restart || (cnt_reg == CNT_LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bit_end     = (cnt_reg == CNT_LAST);
  // Lets the engine register a pulse that lands in the last cycle of a bit.
  assign bit_pre_end = (cnt_reg == CNT_PRE);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one word from the upstream FIFO and sends
// start, LSB-first data, optional parity and stop bits. All outputs registered.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_engine_if.master  bus
);

  localparam int IDX_W    = $clog2(DATA_BITS + 1);
  localparam bit PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  tx_state_e            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 tx_reg, tx_next;
  logic                 rd_en_reg, rd_en_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 baud_restart;
  logic                 bit_end;
  logic                 bit_pre_end;
  logic                 last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (baud_restart),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  assign last_stop = (stop_idx_reg == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
      rd_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      tx_reg       <= tx_next;
      rd_en_reg    <= rd_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    baud_restart  = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!bus.fifo_empty) state_next = REQ;
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        // FIFO output is valid now; parity is frozen here so later FIFO
        // activity cannot disturb the frame.
        state_next   = START;
        shift_next   = bus.fifo_data;
        parity_next  = parity_bit(^bus.fifo_data, PAR_MODE);
        baud_restart = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
            state_next    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          stop_idx_next = 1'b0;
        end
      end
      STOP: begin
        done_next = last_stop && bit_pre_end;
        if (bit_end) begin
          if (last_stop) state_next = IDLE;
          else           stop_idx_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs follow the upcoming state so they change on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    rd_en_next = (state_next == REQ);
    busy_next  = (state_next != IDLE);
  end

  assign bus.tx         = tx_reg;
  assign bus.fifo_rd_en = rd_en_reg;
  assign bus.busy       = busy_reg;
  assign bus.tx_done    = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine: four instances covering no parity,
// even/odd parity and two stop bits, each fed by a registered-read FIFO model.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_engine_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_engine_if #(.DATA_BITS(8)) bus_b ();
  uart_tx_engine_if #(.DATA_BITS(8)) bus_c ();
  uart_tx_engine_if #(.DATA_BITS(8)) bus_d ();

  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.master));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.master));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c.master));
  uart_tx_engine #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut_d (.clk(clk), .reset_n(reset_n), .bus(bus_d.master));

  // FIFO models: initial block appends (mem/wr), clocked block pops (rd/data).
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  logic [7:0] mem_c [8];
  logic [7:0] mem_d [8];
  int wr_a = 0, rd_a = 0;
  int wr_b = 0, rd_b = 0;
  int wr_c = 0, rd_c = 0;
  int wr_d = 0, rd_d = 0;

  assign bus_a.fifo_empty = (rd_a == wr_a);
  assign bus_b.fifo_empty = (rd_b == wr_b);
  assign bus_c.fifo_empty = (rd_c == wr_c);
  assign bus_d.fifo_empty = (rd_d == wr_d);

  always @(posedge clk) begin
    if (bus_a.fifo_rd_en && (rd_a != wr_a)) begin
      bus_a.fifo_data <= mem_a[rd_a % 8];
      rd_a <= rd_a + 1;
    end
    if (bus_b.fifo_rd_en && (rd_b != wr_b)) begin
      bus_b.fifo_data <= mem_b[rd_b % 8];
      rd_b <= rd_b + 1;
    end
    if (bus_c.fifo_rd_en && (rd_c != wr_c)) begin
      bus_c.fifo_data <= mem_c[rd_c % 8];
      rd_c <= rd_c + 1;
    end
    if (bus_d.fifo_rd_en && (rd_d != wr_d)) begin
      bus_d.fifo_data <= mem_d[rd_d % 8];
      rd_d <= rd_d + 1;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    mem_a[0] = 8'hA5;
    wr_a = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_a.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx actual=%b expected=1", bus_a.tx); end
    n_checks++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en actual=%b expected=0", bus_a.fifo_rd_en); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b expected=0", bus_a.busy); end
    n_checks++; if (bus_a.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done actual=%b expected=0", bus_a.tx_done); end
    $display("reset: tx=%b rd_en=%b busy=%b tx_done=%b", bus_a.tx, bus_a.fifo_rd_en, bus_a.busy, bus_a.tx_done);
  endtask

  // 0xA5, no parity; sample k counts cycles after the first edge that sees data.
  task automatic test_single();
    logic [9:0] frame;
    logic exp_tx;
    int rd_cnt;
    frame = {1'b1, 8'hA5, 1'b0};
    rd_cnt = 0;
    reset_n = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (bus_a.fifo_rd_en) rd_cnt++;
      exp_tx = (k >= 3 && k <= 42) ? frame[(k - 3) / 4] : 1'b1;
      n_checks++; if (bus_a.tx !== exp_tx) begin n_fail++; $display("FAIL single_tx k=%0d actual=%b expected=%b", k, bus_a.tx, exp_tx); end
      n_checks++; if (bus_a.tx_done !== (k == 42)) begin n_fail++; $display("FAIL single_done k=%0d actual=%b expected=%b", k, bus_a.tx_done, (k == 42)); end
      n_checks++; if (bus_a.busy !== (k <= 42)) begin n_fail++; $display("FAIL single_busy k=%0d actual=%b expected=%b", k, bus_a.busy, (k <= 42)); end
      n_checks++; if (bus_a.fifo_rd_en !== (k == 1)) begin n_fail++; $display("FAIL single_rd_en k=%0d actual=%b expected=%b", k, bus_a.fifo_rd_en, (k == 1)); end
    end
    n_checks++; if (rd_cnt != 1) begin n_fail++; $display("FAIL single_pops actual=%0d expected=1", rd_cnt); end
    $display("single 0xA5: frame sent, pops=%0d", rd_cnt);
  endtask

  task automatic test_parity();
    logic [10:0] frame_even, frame_odd;
    logic exp_b, exp_c;
    int rd_cnt_b, rd_cnt_c;
    frame_even = {1'b1, 1'b1, 8'h07, 1'b0};
    frame_odd  = {1'b1, 1'b0, 8'h07, 1'b0};
    rd_cnt_b = 0;
    rd_cnt_c = 0;
    mem_b[0] = 8'h07;
    mem_c[0] = 8'h07;
    wr_b = 1;
    wr_c = 1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (bus_b.fifo_rd_en) rd_cnt_b++;
      if (bus_c.fifo_rd_en) rd_cnt_c++;
      exp_b = (k >= 3 && k <= 46) ? frame_even[(k - 3) / 4] : 1'b1;
      exp_c = (k >= 3 && k <= 46) ? frame_odd[(k - 3) / 4] : 1'b1;
      n_checks++; if (bus_b.tx !== exp_b) begin n_fail++; $display("FAIL parity_even_tx k=%0d actual=%b expected=%b", k, bus_b.tx, exp_b); end
      n_checks++; if (bus_c.tx !== exp_c) begin n_fail++; $display("FAIL parity_odd_tx k=%0d actual=%b expected=%b", k, bus_c.tx, exp_c); end
      n_checks++; if (bus_b.tx_done !== (k == 46)) begin n_fail++; $display("FAIL parity_even_done k=%0d actual=%b expected=%b", k, bus_b.tx_done, (k == 46)); end
      n_checks++; if (bus_c.tx_done !== (k == 46)) begin n_fail++; $display("FAIL parity_odd_done k=%0d actual=%b expected=%b", k, bus_c.tx_done, (k == 46)); end
      n_checks++; if (bus_b.busy !== (k <= 46)) begin n_fail++; $display("FAIL parity_even_busy k=%0d actual=%b expected=%b", k, bus_b.busy, (k <= 46)); end
    end
    n_checks++; if (rd_cnt_b != 1) begin n_fail++; $display("FAIL parity_even_pops actual=%0d expected=1", rd_cnt_b); end
    n_checks++; if (rd_cnt_c != 1) begin n_fail++; $display("FAIL parity_odd_pops actual=%0d expected=1", rd_cnt_c); end
    $display("parity 0x07: even and odd frames sent, pops=%0d/%0d", rd_cnt_b, rd_cnt_c);
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    logic exp_tx;
    int rd_cnt;
    f1 = {1'b1, 8'h00, 1'b0};
    f2 = {1'b1, 8'hFF, 1'b0};
    rd_cnt = 0;
    mem_a[1] = 8'h00;
    mem_a[2] = 8'hFF;
    wr_a = 3;
    for (int k = 1; k <= 95; k++) begin
      @(negedge clk);
      if (bus_a.fifo_rd_en) rd_cnt++;
      if (k >= 3 && k <= 42)       exp_tx = f1[(k - 3) / 4];
      else if (k >= 46 && k <= 85) exp_tx = f2[(k - 46) / 4];
      else                         exp_tx = 1'b1;
      n_checks++; if (bus_a.tx !== exp_tx) begin n_fail++; $display("FAIL b2b_tx k=%0d actual=%b expected=%b", k, bus_a.tx, exp_tx); end
      n_checks++; if (bus_a.tx_done !== (k == 42 || k == 85)) begin n_fail++; $display("FAIL b2b_done k=%0d actual=%b expected=%b", k, bus_a.tx_done, (k == 42 || k == 85)); end
      n_checks++; if (bus_a.fifo_rd_en !== (k == 1 || k == 44)) begin n_fail++; $display("FAIL b2b_rd_en k=%0d actual=%b expected=%b", k, bus_a.fifo_rd_en, (k == 1 || k == 44)); end
      n_checks++; if (bus_a.busy !== (k <= 42 || (k >= 44 && k <= 85))) begin n_fail++; $display("FAIL b2b_busy k=%0d actual=%b", k, bus_a.busy); end
    end
    n_checks++; if (rd_cnt != 2) begin n_fail++; $display("FAIL b2b_pops actual=%0d expected=2", rd_cnt); end
    $display("back_to_back 0x00,0xFF: pops=%0d", rd_cnt);
  endtask

  task automatic test_stop2();
    logic [10:0] frame;
    logic exp_tx;
    frame = {1'b1, 1'b1, 8'h3C, 1'b0};
    mem_d[0] = 8'h3C;
    wr_d = 1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      exp_tx = (k >= 3 && k <= 24) ? frame[(k - 3) / 2] : 1'b1;
      n_checks++; if (bus_d.tx !== exp_tx) begin n_fail++; $display("FAIL stop2_tx k=%0d actual=%b expected=%b", k, bus_d.tx, exp_tx); end
      n_checks++; if (bus_d.tx_done !== (k == 24)) begin n_fail++; $display("FAIL stop2_done k=%0d actual=%b expected=%b", k, bus_d.tx_done, (k == 24)); end
      n_checks++; if (bus_d.busy !== (k <= 24)) begin n_fail++; $display("FAIL stop2_busy k=%0d actual=%b expected=%b", k, bus_d.busy, (k <= 24)); end
    end
    $display("stop2 0x3C: frame of 22 cycles checked");
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    mem_a[3] = 8'hF0;
    wr_a = 4;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_a.tx_done) done_cnt++;
    end
    // Sample 20 lies in data bit 3, which is 0 for 0xF0.
    n_checks++; if (bus_a.tx !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_tx actual=%b expected=0", bus_a.tx); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (bus_a.tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx actual=%b expected=1", bus_a.tx); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy actual=%b expected=0", bus_a.busy); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_a.tx_done) done_cnt++;
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_a.tx_done) done_cnt++;
      n_checks++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en k=%0d actual=%b expected=0", k, bus_a.fifo_rd_en); end
      n_checks++; if (bus_a.tx !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_tx k=%0d actual=%b expected=1", k, bus_a.tx); end
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_busy k=%0d actual=%b expected=0", k, bus_a.busy); end
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_done actual=%0d expected=0", done_cnt); end
    $display("reset_mid: abandoned frame, tx_done pulses=%0d", done_cnt);
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (3) @(negedge clk);
    test_parity();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_stop2();
    repeat (3) @(negedge clk);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
